// File: rtl/forward_dispatch_pkg.sv
// Shared types and constants for the forwarding/dispatch stage:
// port geometry, descriptor field widths and the FIFO entry layout.
package forward_dispatch_pkg;

  localparam int NUM_PORTS = 9;
  localparam int HOST_PORT = 8;
  localparam int BUFID_W   = 9;
  localparam int TYPE_W    = 3;
  localparam int ADDR_W    = 5;
  localparam int INPORT_W  = 4;
  localparam int CNT_W     = 4;
  localparam int DROP_W    = 16;

  typedef struct packed {
    logic [NUM_PORTS-1:0] bitmap;
    logic [BUFID_W-1:0]   bufid;
    logic [TYPE_W-1:0]    ptype;
    logic [ADDR_W-1:0]    addr;
    logic [INPORT_W-1:0]  inport;
  } fd_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } fd_state_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PORTS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PORTS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/fd_desc_fifo.sv
// Show-ahead descriptor FIFO: the head entry is visible on rdata_o while
// the FIFO is non-empty, so the dispatcher can load it in the pop cycle.
module fd_desc_fifo
  import forward_dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  logic      pop_i,
  input  fd_entry_t wdata_i,
  output fd_entry_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = $clog2(DEPTH);

  fd_entry_t       mem [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q;

  // Storage is not reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem[rptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/forward_dispatch.sv
// Resolves and prunes the outport bitmap of each incoming descriptor, buffers
// it, then fans it out to every destination egress queue under per-port ready.
module forward_dispatch
  import forward_dispatch_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] iv_outport,
  input  logic                 i_outport_wr,
  input  logic [NUM_PORTS-1:0] iv_ram_rdata,
  input  logic [BUFID_W-1:0]   iv_pkt_bufid,
  input  logic [TYPE_W-1:0]    iv_pkt_type,
  input  logic [ADDR_W-1:0]    iv_submit_addr,
  input  logic [INPORT_W-1:0]  iv_inport,
  input  logic                 i_pkt_bufid_wr,
  input  logic [NUM_PORTS-1:0] iv_port_ready,
  output logic [NUM_PORTS-1:0] ov_port_wr,
  output logic [BUFID_W-1:0]   ov_pkt_bufid,
  output logic [TYPE_W-1:0]    ov_pkt_type,
  output logic [ADDR_W-1:0]    ov_submit_addr,
  output logic [INPORT_W-1:0]  ov_inport,
  output logic [CNT_W-1:0]     ov_bufid_cnt,
  output logic                 o_bufid_cnt_wr,
  output logic [BUFID_W-1:0]   ov_free_bufid,
  output logic                 o_free_bufid_wr,
  output logic [DROP_W-1:0]    ov_drop_cnt
);

  logic [NUM_PORTS-1:0] raw_bitmap, prune_mask, in_bitmap;
  logic                 in_drop, in_free;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  fd_entry_t            fifo_wdata, fifo_rdata;

  fd_state_e            state_q, state_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d, pending_left;

  logic [BUFID_W-1:0]   bufid_q, free_bufid_q;
  logic [TYPE_W-1:0]    type_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [INPORT_W-1:0]  inport_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 cnt_wr_q, free_wr_q;
  logic [DROP_W-1:0]    drop_cnt_q;

  // Input stage: pick the bitmap source and never send a packet back out its ingress port.
  always_comb begin
    raw_bitmap = i_outport_wr ? iv_outport : iv_ram_rdata;
    prune_mask = (iv_inport <= INPORT_W'(HOST_PORT)) ? (NUM_PORTS'(1) << iv_inport) : '0;
    in_bitmap  = raw_bitmap & ~prune_mask;
    in_drop    = i_pkt_bufid_wr && (in_bitmap != '0) && fifo_full && !fifo_pop;
    fifo_push  = i_pkt_bufid_wr && (in_bitmap != '0) && !in_drop;
    in_free    = i_pkt_bufid_wr && ((in_bitmap == '0) || in_drop);
  end

  assign fifo_wdata = '{bitmap: in_bitmap, bufid: iv_pkt_bufid, ptype: iv_pkt_type,
                        addr: iv_submit_addr, inport: iv_inport};

  fd_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    fifo_pop     = 1'b0;
    ov_port_wr   = '0;
    pending_left = pending_q & ~iv_port_ready;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ov_port_wr = pending_q & iv_port_ready;
        pending_d  = pending_left;
        if (pending_left == '0) begin
          if (!fifo_empty) fifo_pop = 1'b1;
          else             state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fifo_pop) pending_d = fifo_rdata.bitmap;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      bufid_q      <= '0;
      type_q       <= '0;
      addr_q       <= '0;
      inport_q     <= '0;
      cnt_q        <= '0;
      cnt_wr_q     <= 1'b0;
      free_wr_q    <= 1'b0;
      free_bufid_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_wr_q  <= fifo_pop;
      free_wr_q <= in_free;
      if (fifo_pop) begin
        bufid_q  <= fifo_rdata.bufid;
        type_q   <= fifo_rdata.ptype;
        addr_q   <= fifo_rdata.addr;
        inport_q <= fifo_rdata.inport;
        cnt_q    <= popcount(fifo_rdata.bitmap);
      end
      if (in_free) free_bufid_q <= iv_pkt_bufid;
      if (in_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  assign ov_pkt_bufid    = bufid_q;
  assign ov_pkt_type     = type_q;
  assign ov_submit_addr  = addr_q;
  assign ov_inport       = inport_q;
  assign ov_bufid_cnt    = cnt_q;
  assign o_bufid_cnt_wr  = cnt_wr_q;
  assign ov_free_bufid   = free_bufid_q;
  assign o_free_bufid_wr = free_wr_q;
  assign ov_drop_cnt     = drop_cnt_q;

endmodule
